// File: rtl/call_stack.sv
// Hardware LIFO return-address stack for the FRANK6000 core: push on CALL, pop on RET.
// Optional build macro CALL_STACK_WRAP_EN makes a push while full overwrite the oldest entry.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_D,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_Q,
  output logic [AW:0]      or_count,
  output logic             or_empty,
  output logic             or_full,
  output logic             or_err
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    base;

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_slot;
  logic [AW-1:0]    base_next;
  logic [AW:0]      count_next;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic             err_set;
  logic             err_next;

  // Slot arithmetic is AW bits wide so it wraps modulo DEPTH for free.
  assign top_idx   = base + or_count[AW-1:0] - AW'(1);
  assign push_slot = base + or_count[AW-1:0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    count_next = or_count;
    base_next  = base;
    wr_en      = 1'b0;
    wr_addr    = push_slot;
    err_set    = 1'b0;
    unique case ({i_push, i_pop})
      2'b10: begin
        if (!or_full) begin
          wr_en      = 1'b1;
          count_next = or_count + (AW+1)'(1);
        end else begin
`ifdef CALL_STACK_WRAP_EN
          // When full, push_slot equals base: the oldest entry is overwritten and
          // base advances, so the new value becomes the top.
          wr_en     = 1'b1;
          base_next = base + AW'(1);
`else
          err_set   = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!or_empty) count_next = or_count - (AW+1)'(1);
        else           err_set    = 1'b1;
      end
      2'b11: begin
        // Tail call: replace the top in place, or behave as a plain push when empty.
        wr_en = 1'b1;
        if (or_empty) count_next = (AW+1)'(1);
        else          wr_addr    = top_idx;
      end
      default: ;
    endcase
    err_next = err_set | (or_err & ~i_clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      base     <= '0;
      or_count <= '0;
      or_empty <= 1'b1;
      or_full  <= 1'b0;
      or_err   <= 1'b0;
    end else begin
      base     <= base_next;
      or_count <= count_next;
      or_empty <= (count_next == '0);
      or_full  <= (count_next == FULL_COUNT);
      or_err   <= err_next;
    end
  end

  // NOTE: the storage array has no reset; slots are only read once written, so they need none.
  always_ff @(posedge i_clk) begin
    if (wr_en && i_rst) mem[wr_addr] <= i_D;
  end

  assign o_Q = or_empty ? '0 : mem[top_idx];

  a_flags_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst)
    !(or_empty && or_full));
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst)
    or_count <= FULL_COUNT);
  a_empty_tracks_count: assert property (@(posedge i_clk) disable iff (!i_rst)
    or_empty == (or_count == '0));

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: a queue model checked every cycle, plus
// directed sequences with literal expectations. Honours CALL_STACK_WRAP_EN.
module tb_call_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             i_clk;
  logic             i_rst;
  logic             i_push;
  logic             i_pop;
  logic [WIDTH-1:0] i_D;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_Q;
  logic [AW:0]      or_count;
  logic             or_empty;
  logic             or_full;
  logic             or_err;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_err;

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_push),
    .i_pop     (i_pop),
    .i_D       (i_D),
    .i_clr_err (i_clr_err),
    .o_Q       (o_Q),
    .or_count  (or_count),
    .or_empty  (or_empty),
    .or_full   (or_full),
    .or_err    (or_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #10 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LIFO model: the back of the queue is the top of stack.
  always @(posedge i_clk or negedge i_rst) begin : model
    bit set;
    set = 1'b0;
    if (!i_rst) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (model_q.size() < DEPTH) model_q.push_back(i_D);
          else begin
`ifdef CALL_STACK_WRAP_EN
            void'(model_q.pop_front());
            model_q.push_back(i_D);
`else
            set = 1'b1;
`endif
          end
        end
        2'b01: begin
          if (model_q.size() > 0) void'(model_q.pop_back());
          else set = 1'b1;
        end
        2'b11: begin
          if (model_q.size() > 0) model_q[model_q.size()-1] = i_D;
          else model_q.push_back(i_D);
        end
        default: ;
      endcase
      if (set) model_err = 1'b1;
      else if (i_clr_err) model_err = 1'b0;
    end
  end

  always @(negedge i_clk) begin
    if (started) begin
      check("count", 32'(or_count), model_q.size());
      check("empty", 32'(or_empty), 32'(model_q.size() == 0));
      check("full", 32'(or_full), 32'(model_q.size() == DEPTH));
      check("err", 32'(or_err), 32'(model_err));
      check("q", 32'(o_Q), (model_q.size() > 0) ? 32'(model_q[model_q.size()-1]) : 32'h0);
    end
  end

  task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    i_push = p; i_pop = q; i_D = d; i_clr_err = c;
    @(posedge i_clk);
    #1;
    i_push = 1'b0; i_pop = 1'b0; i_clr_err = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_push = 1'b0; i_pop = 1'b0; i_D = '0; i_clr_err = 1'b0;
    #1 i_rst = 1'b0;
    #1 started = 1'b1;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      i_push = 1'($urandom); i_pop = 1'($urandom); i_D = 8'($urandom);
      @(posedge i_clk);
      #1;
      check("rst_count", 32'(or_count), 0);
      check("rst_empty", 32'(or_empty), 1);
      check("rst_full", 32'(or_full), 0);
      check("rst_err", 32'(or_err), 0);
      check("rst_q", 32'(o_Q), 0);
    end
    i_push = 1'b0; i_pop = 1'b0;
    i_rst = 1'b1;

`ifdef CALL_STACK_WRAP_EN
    for (int i = 0; i <= 8; i++) op(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    check("wrap_count", 32'(or_count), 8);
    check("wrap_q", 32'(o_Q), 32'h18);
    check("wrap_err", 32'(or_err), 0);
    for (int i = 0; i < 8; i++) begin
      check("wrap_drain_q", 32'(o_Q), 32'(8'h18 - i));
      op(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("wrap_drain_empty", 32'(or_empty), 1);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    check("wrap_under_err", 32'(or_err), 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);
`else
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    check("fill_full", 32'(or_full), 1);
    check("fill_count", 32'(or_count), 8);
    check("fill_q", 32'(o_Q), 32'h17);
    check("fill_err", 32'(or_err), 0);
    op(1'b1, 1'b0, 8'h55, 1'b0);
    check("over_count", 32'(or_count), 8);
    check("over_q", 32'(o_Q), 32'h17);
    check("over_err", 32'(or_err), 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_err", 32'(or_err), 0);
    for (int i = 0; i < 8; i++) begin
      check("drain_q", 32'(o_Q), 32'(8'h17 - i));
      op(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain_empty", 32'(or_empty), 1);
    check("drain_q0", 32'(o_Q), 0);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    check("under_count", 32'(or_count), 0);
    check("under_err", 32'(or_err), 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);
`endif

    // Tail call replaces the top.
    op(1'b1, 1'b0, 8'hA1, 1'b0);
    op(1'b1, 1'b1, 8'hB2, 1'b0);
    check("repl_count", 32'(or_count), 1);
    check("repl_q", 32'(o_Q), 32'hB2);
    check("repl_err", 32'(or_err), 0);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    check("repl_empty", 32'(or_empty), 1);

    // Asynchronous reset mid-cycle.
    op(1'b1, 1'b0, 8'h01, 1'b0);
    op(1'b1, 1'b0, 8'h02, 1'b0);
    op(1'b1, 1'b0, 8'h03, 1'b0);
    check("pre_rst_count", 32'(or_count), 3);
    #4 i_rst = 1'b0;
    #1;
    check("async_count", 32'(or_count), 0);
    check("async_empty", 32'(or_empty), 1);
    check("async_q", 32'(o_Q), 0);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    op(1'b1, 1'b0, 8'h04, 1'b0);
    check("post_rst_count", 32'(or_count), 1);
    check("post_rst_q", 32'(o_Q), 32'h04);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 70 : 30;
      i_push    = ($urandom_range(0, 99) < bias);
      i_pop     = ($urandom_range(0, 99) < (100 - bias));
      i_D       = 8'($urandom);
      i_clr_err = ($urandom_range(0, 9) == 0);
      @(posedge i_clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        #2 i_rst = 1'b0;
        @(posedge i_clk);
        #3 i_rst = 1'b1;
      end
    end
    i_push = 1'b0; i_pop = 1'b0; i_clr_err = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
